// File: rtl/peripheral_bus.sv
// Memory-mapped timer / LED / 7-seg / switch block on the CPU load/store bus.
// Optional free-running cycle counter at offset 0x18 when SYSTICK_EN is defined.
module peripheral_bus #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          LED_W     = 8,
   parameter int          SW_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       Address,
   input  logic [31:0]       Write_data,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [31:0]       Read_data,
   input  logic [SW_W-1:0]   switch,
   output logic [LED_W-1:0]  led,
   output logic [11:0]       digi,
   output logic              irqout
);

   // Register word indices (Address[7:2])
   localparam logic [5:0] OFS_TH      = 6'h00;
   localparam logic [5:0] OFS_TL      = 6'h01;
   localparam logic [5:0] OFS_TCON    = 6'h02;
   localparam logic [5:0] OFS_LED     = 6'h03;
   localparam logic [5:0] OFS_SWITCH  = 6'h04;
   localparam logic [5:0] OFS_DIGI    = 6'h05;
`ifdef SYSTICK_EN
   localparam logic [5:0] OFS_SYSTICK = 6'h06;
`endif

   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   logic [31:0]      th_reg,   th_next;
   logic [31:0]      tl_reg,   tl_next;
   logic [2:0]       tcon_reg, tcon_next;
   logic [LED_W-1:0] led_reg,  led_next;
   logic [11:0]      digi_reg, digi_next;
   logic [SW_W-1:0]  sw_meta_reg;
   logic [SW_W-1:0]  sw_sync_reg;
`ifdef SYSTICK_EN
   logic [31:0]      systick_reg;
`endif

   logic        hit;
   logic [5:0]  word;
   logic        wr_en;
   logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
   logic        tl_max;
   logic        overflow;
   logic        irq_set;
   logic [31:0] led_ext;
   logic [31:0] sw_ext;
   logic [31:0] read_data;
   logic        unused_addr_bits;

   assign hit              = (Address[31:8] == BASE_ADDR[31:8]);
   assign word             = Address[7:2];
   assign unused_addr_bits = &{1'b0, Address[1:0]};

   // ---------------------------------------------------------------
   // Write decode
   // ---------------------------------------------------------------
   always_comb begin
      wr_en   = MemWrite && hit;
      wr_th   = 1'b0;
      wr_tl   = 1'b0;
      wr_tcon = 1'b0;
      wr_led  = 1'b0;
      wr_digi = 1'b0;
      if (wr_en) begin
         case (word)
            OFS_TH:   wr_th   = 1'b1;
            OFS_TL:   wr_tl   = 1'b1;
            OFS_TCON: wr_tcon = 1'b1;
            OFS_LED:  wr_led  = 1'b1;
            OFS_DIGI: wr_digi = 1'b1;
            default:  ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Timer next-state
   // ---------------------------------------------------------------
   always_comb begin
      tl_max   = (tl_reg == ALL_ONES);
      overflow = tcon_reg[0] && tl_max;
      irq_set  = overflow && tcon_reg[1];

      th_next = th_reg;
      if (wr_th) begin
         th_next = Write_data;
      end

      // A bus store to TL beats the count; a wrap reloads the pre-store TH.
      tl_next = tl_reg;
      if (wr_tl) begin
         tl_next = Write_data;
      end else if (tcon_reg[0]) begin
         if (tl_max) begin
            tl_next = th_reg;
         end else begin
            tl_next = tl_reg + 32'd1;
         end
      end

      // Status set by a wrap is never lost to a simultaneous software clear.
      tcon_next = tcon_reg;
      if (wr_tcon) begin
         tcon_next = {Write_data[2] | irq_set, Write_data[1:0]};
      end else begin
         tcon_next = {tcon_reg[2] | irq_set, tcon_reg[1:0]};
      end
   end

   // ---------------------------------------------------------------
   // Output register next-state
   // ---------------------------------------------------------------
   always_comb begin
      led_next  = led_reg;
      digi_next = digi_reg;
      if (wr_led) begin
         led_next = Write_data[LED_W-1:0];
      end
      if (wr_digi) begin
         digi_next = Write_data[11:0];
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_reg   <= '0;
         tl_reg   <= '0;
         tcon_reg <= '0;
         led_reg  <= '0;
         digi_reg <= '0;
      end else begin
         th_reg   <= th_next;
         tl_reg   <= tl_next;
         tcon_reg <= tcon_next;
         led_reg  <= led_next;
         digi_reg <= digi_next;
      end
   end

   // Two-flop synchroniser for the asynchronous board switches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         sw_meta_reg <= switch;
         sw_sync_reg <= sw_meta_reg;
      end
   end

`ifdef SYSTICK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         systick_reg <= '0;
      end else begin
         systick_reg <= systick_reg + 32'd1;
      end
   end
`endif

   // ---------------------------------------------------------------
   // Combinational read mux
   // ---------------------------------------------------------------
   always_comb begin
      led_ext              = '0;
      led_ext[LED_W-1:0]   = led_reg;
      sw_ext               = '0;
      sw_ext[SW_W-1:0]     = sw_sync_reg;
   end

   always_comb begin
      read_data = 32'h0;
      if (MemRead && hit) begin
         case (word)
            OFS_TH:      read_data = th_reg;
            OFS_TL:      read_data = tl_reg;
            OFS_TCON:    read_data = {29'd0, tcon_reg};
            OFS_LED:     read_data = led_ext;
            OFS_SWITCH:  read_data = sw_ext;
            OFS_DIGI:    read_data = {20'd0, digi_reg};
`ifdef SYSTICK_EN
            OFS_SYSTICK: read_data = systick_reg;
`endif
            default:     read_data = 32'h0;
         endcase
      end
   end

   assign Read_data = read_data;
   assign led       = led_reg;
   assign digi      = digi_reg;
   assign irqout    = tcon_reg[1] & tcon_reg[2];

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed testbench for peripheral_bus: timer, irq, LED/7-seg, switch sync, decode, reset.
module tb_peripheral_bus;

   localparam logic [31:0] A_TH      = 32'h4000_0000;
   localparam logic [31:0] A_TL      = 32'h4000_0004;
   localparam logic [31:0] A_TCON    = 32'h4000_0008;
   localparam logic [31:0] A_LED     = 32'h4000_000C;
   localparam logic [31:0] A_SW      = 32'h4000_0010;
   localparam logic [31:0] A_DIGI    = 32'h4000_0014;
   localparam logic [31:0] A_SYSTICK = 32'h4000_0018;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Read_data;
   logic [7:0]  switch;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   int vectors;
   int miscompares;

   peripheral_bus dut (
      .clk        (clk),
      .reset      (reset),
      .Address    (Address),
      .Write_data (Write_data),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Read_data  (Read_data),
      .switch     (switch),
      .led        (led),
      .digi       (digi),
      .irqout     (irqout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called just after a rising edge; the store commits on the next edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      Address    = a;
      Write_data = d;
      MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      MemWrite   = 1'b0;
      Address    = 32'h0;
      $display("[%0t] wr %h <= %h", $time, a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      Address = a;
      MemRead = 1'b1;
      #1;
      d       = Read_data;
      MemRead = 1'b0;
      Address = 32'h0;
      $display("[%0t] rd %h => %h", $time, a, d);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      #12;
      vectors++;
      if (led !== 8'h00 || digi !== 12'h000 || irqout !== 1'b0) begin
         $display("FAIL reset_outputs: got led=%h digi=%h irq=%b expected 00 000 0", led, digi, irqout);
         miscompares++;
      end
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL reset_tl: got %h expected 0", d); miscompares++; end
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL reset_tcon: got %h expected 0", d); miscompares++; end
      Address = A_LED;
      MemRead = 1'b0;
      #1;
      vectors++;
      if (Read_data !== 32'h0) begin $display("FAIL reset_noread: got %h expected 0", Read_data); miscompares++; end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_timer_overflow;
      logic [31:0] d;
      bus_write(A_TH, 32'hFFFF_FFFC);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h3);
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFE) begin $display("FAIL tmr_start: got %h expected fffffffe", d); miscompares++; end
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFF || irqout !== 1'b0) begin
         $display("FAIL tmr_inc: got tl=%h irq=%b expected ffffffff 0", d, irqout); miscompares++;
      end
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFC) begin $display("FAIL tmr_reload: got %h expected fffffffc", d); miscompares++; end
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h7 || irqout !== 1'b1) begin
         $display("FAIL tmr_irq: got tcon=%h irq=%b expected 7 1", d, irqout); miscompares++;
      end
   endtask

   task automatic test_irq_clear;
      logic [31:0] d;
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h3 || irqout !== 1'b0) begin
         $display("FAIL irq_clear: got tcon=%h irq=%b expected 3 0", d, irqout); miscompares++;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h7 || irqout !== 1'b1) begin
         $display("FAIL irq_clear_on_ovf: got tcon=%h irq=%b expected 7 1", d, irqout); miscompares++;
      end
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFC) begin $display("FAIL irq_clear_reload: got %h expected fffffffc", d); miscompares++; end
   endtask

   task automatic test_tl_store;
      logic [31:0] d;
      bus_write(A_TL, 32'h0000_0100);
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0000_0100) begin $display("FAIL tl_store_wins: got %h expected 00000100", d); miscompares++; end
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0000_0101) begin $display("FAIL tl_store_count: got %h expected 00000101", d); miscompares++; end
   endtask

   task automatic test_th_store_overflow;
      logic [31:0] d;
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TH, 32'h0000_0055);
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFC) begin $display("FAIL th_old_reload: got %h expected fffffffc", d); miscompares++; end
      bus_read(A_TH, d);
      vectors++;
      if (d !== 32'h0000_0055) begin $display("FAIL th_new_value: got %h expected 00000055", d); miscompares++; end
      bus_write(A_TL, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0000_0055) begin $display("FAIL th_next_wrap: got %h expected 00000055", d); miscompares++; end
   endtask

   task automatic test_th_max;
      logic [31:0] d;
      bus_write(A_TCON, 32'h0);
      bus_write(A_TCON, 32'h0);
      bus_write(A_TH, 32'hFFFF_FFFF);
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h3) begin $display("FAIL thmax_arm: got %h expected 3", d); miscompares++; end
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'hFFFF_FFFF || irqout !== 1'b1) begin
         $display("FAIL thmax_wrap: got tl=%h irq=%b expected ffffffff 1", d, irqout); miscompares++;
      end
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h7) begin $display("FAIL thmax_every_cycle: got %h expected 7", d); miscompares++; end
   endtask

   task automatic test_timer_hold;
      logic [31:0] d;
      // Stop on an overflow edge: run/enable cleared, status still set by the wrap.
      bus_write(A_TCON, 32'h0);
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h4 || irqout !== 1'b0) begin
         $display("FAIL hold_stop: got tcon=%h irq=%b expected 4 0", d, irqout); miscompares++;
      end
      bus_write(A_TL, 32'h0000_1234);
      bus_write(A_TCON, 32'h6);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0000_1234) begin $display("FAIL hold_tl: got %h expected 00001234", d); miscompares++; end
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h6 || irqout !== 1'b1) begin
         $display("FAIL hold_tcon: got tcon=%h irq=%b expected 6 1", d, irqout); miscompares++;
      end
   endtask

   task automatic test_led_switch;
      logic [31:0] d;
      bus_write(A_LED, 32'h1234_56A5);
      bus_read(A_LED, d);
      vectors++;
      if (led !== 8'hA5 || d !== 32'h0000_00A5) begin
         $display("FAIL led_write: got led=%h rd=%h expected a5 000000a5", led, d); miscompares++;
      end
      switch = 8'h3C;
      bus_read(A_SW, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL sw_edge0: got %h expected 0", d); miscompares++; end
      @(posedge clk); #1;
      bus_read(A_SW, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL sw_edge1: got %h expected 0", d); miscompares++; end
      @(posedge clk); #1;
      bus_read(A_SW, d);
      vectors++;
      if (d !== 32'h0000_003C) begin $display("FAIL sw_edge2: got %h expected 0000003c", d); miscompares++; end
      bus_write(A_SW, 32'h0000_00FF);
      bus_read(A_SW, d);
      vectors++;
      if (d !== 32'h0000_003C || led !== 8'hA5) begin
         $display("FAIL sw_ro: got sw=%h led=%h expected 0000003c a5", d, led); miscompares++;
      end
      bus_write(A_DIGI, 32'hFFFF_F123);
      bus_read(A_DIGI, d);
      vectors++;
      if (digi !== 12'h123 || d !== 32'h0000_0123) begin
         $display("FAIL digi_write: got digi=%h rd=%h expected 123 00000123", digi, d); miscompares++;
      end
   endtask

   task automatic test_decode;
      logic [31:0] d;
      bus_read(32'h4000_0020, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL unmapped_read: got %h expected 0", d); miscompares++; end
      bus_read(32'h4000_000F, d);
      vectors++;
      if (d !== 32'h0000_00A5) begin $display("FAIL low_bits_ignored: got %h expected 000000a5", d); miscompares++; end
      Address = A_LED;
      MemRead = 1'b0;
      #1;
      vectors++;
      if (Read_data !== 32'h0) begin $display("FAIL no_memread: got %h expected 0", Read_data); miscompares++; end
      bus_write(32'h3000_000C, 32'h0000_0011);
      vectors++;
      if (led !== 8'hA5) begin $display("FAIL miss_write: got %h expected a5", led); miscompares++; end
      bus_read(32'h3000_000C, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL miss_read: got %h expected 0", d); miscompares++; end
   endtask

   task automatic test_systick;
      logic [31:0] d1;
      logic [31:0] d2;
`ifdef SYSTICK_EN
      bus_read(A_SYSTICK, d1);
      repeat (5) @(posedge clk);
      #1;
      bus_read(A_SYSTICK, d2);
      vectors++;
      if (d2 - d1 !== 32'd5) begin $display("FAIL systick_delta: got %0d expected 5", d2 - d1); miscompares++; end
`else
      bus_read(A_SYSTICK, d1);
      d2 = 32'h0;
      vectors++;
      if (d1 !== d2) begin $display("FAIL systick_absent: got %h expected 0", d1); miscompares++; end
`endif
   endtask

   task automatic test_async_reset;
      logic [31:0] d;
      bus_write(A_TCON, 32'h7);
      @(posedge clk);
      vectors++;
      #1;
      if (irqout !== 1'b1) begin $display("FAIL pre_reset_irq: got %b expected 1", irqout); miscompares++; end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (led !== 8'h00 || digi !== 12'h000 || irqout !== 1'b0) begin
         $display("FAIL async_outputs: got led=%h digi=%h irq=%b expected 00 000 0", led, digi, irqout);
         miscompares++;
      end
      bus_read(A_TL, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL async_tl: got %h expected 0", d); miscompares++; end
      bus_read(A_TH, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL async_th: got %h expected 0", d); miscompares++; end
      bus_read(A_TCON, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL async_tcon: got %h expected 0", d); miscompares++; end
      bus_read(A_SW, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL async_switch: got %h expected 0", d); miscompares++; end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      Address     = 32'h0;
      Write_data  = 32'h0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      switch      = 8'h00;
      test_reset;
      test_timer_overflow;
      test_irq_clear;
      test_tl_store;
      test_th_store_overflow;
      test_th_max;
      test_timer_hold;
      test_led_switch;
      test_decode;
      test_systick;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
